// File: rtl/demux_1x2_8bits.sv
// rtl/demux_1x2_8bits.sv - RX 1:2 byte demux, slot selector phase-locked to TX mux by common reset
// Optional pair-aligned release under `DEMUX_PAIR_ALIGN_EN.
module demux_1x2_8bits #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out0,
  output logic              valid_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid_out1,
  output logic              sel_phase,
  output logic [CNT_W-1:0]  byte_cnt0,
  output logic [CNT_W-1:0]  byte_cnt1,
  output logic              pair_err
);

  logic              sel;
  logic              deliver0;
  logic              deliver1;
  logic [DATA_W-1:0] next_data0;
  logic [DATA_W-1:0] next_data1;

  assign sel_phase = sel;

  // Free-running: must toggle regardless of valid_in to stay in step with TX.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sel <= 1'b0;
    end else begin
      sel <= ~sel;
    end
  end

`ifdef DEMUX_PAIR_ALIGN_EN
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;
  logic              err_next;

  always_comb begin
    deliver0   = 1'b0;
    deliver1   = 1'b0;
    err_next   = 1'b0;
    next_data0 = hold_data;
    next_data1 = data_in;
    if (sel) begin
      deliver0 = valid_in & hold_valid;
      deliver1 = valid_in & hold_valid;
      // Either half of the pair missing drops whatever is present.
      err_next = valid_in ^ hold_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      pair_err   <= 1'b0;
    end else begin
      pair_err <= err_next;
      if (!sel) begin
        hold_valid <= valid_in;
        if (valid_in) begin
          hold_data <= data_in;
        end
      end else begin
        hold_valid <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    deliver0   = valid_in & ~sel;
    deliver1   = valid_in & sel;
    next_data0 = data_in;
    next_data1 = data_in;
  end

  assign pair_err = 1'b0;
`endif

  // Data registers hold between deliveries; only the qualifiers pulse.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out0  <= '0;
      data_out1  <= '0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      byte_cnt0  <= '0;
      byte_cnt1  <= '0;
    end else begin
      valid_out0 <= deliver0;
      valid_out1 <= deliver1;
      if (deliver0) begin
        data_out0 <= next_data0;
        byte_cnt0 <= byte_cnt0 + CNT_W'(1);
      end
      if (deliver1) begin
        data_out1 <= next_data1;
        byte_cnt1 <= byte_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule
